// File: rtl/softmax_normalizer.sv
// Softmax normalizer: buffers one frame of exponentials, sums it and hands the sum to an
// external reciprocal unit, then streams each value scaled by the returned reciprocal.
`timescale 1ns/1ps
module softmax_normalizer #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned FRACTION_BITS = 30,
   parameter int unsigned NUM_CLASSES   = 10,
   parameter int unsigned CNT_WIDTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] sum_out,
   output logic                  sum_valid,
   input  logic [DATA_WIDTH-1:0] recip_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);

   localparam int unsigned ACC_WIDTH = DATA_WIDTH + CNT_WIDTH;
   localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {S_LOAD, S_RECIP, S_OUT} state_t;

   state_t                 state, state_next;
   logic [DATA_WIDTH-1:0]  frame_buf [NUM_CLASSES];
   logic [CNT_WIDTH-1:0]   wr_cnt, rd_cnt;
   logic [ACC_WIDTH-1:0]   acc, acc_sum;
   logic [DATA_WIDTH-1:0]  sum_sat;
   logic [DATA_WIDTH-1:0]  recip_reg;
   logic [PROD_WIDTH-1:0]  product, scaled;
   logic                   accept, out_fire;

   assign accept   = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign acc_sum  = acc + ACC_WIDTH'(in_data);
   assign sum_sat  = (|acc_sum[ACC_WIDTH-1:DATA_WIDTH]) ? '1 : acc_sum[DATA_WIDTH-1:0];

   assign product = PROD_WIDTH'(frame_buf[rd_cnt]) * PROD_WIDTH'(recip_reg);
   assign scaled  = product >> FRACTION_BITS;

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      sum_valid  = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_data   = '0;
      case (state)
         S_LOAD: begin
            in_ready = ~rst;
            if (accept && wr_cnt == LAST_IDX)
               state_next = S_RECIP;
         end
         S_RECIP: begin
            sum_valid  = 1'b1;
            state_next = S_OUT;
         end
         S_OUT: begin
            out_valid = 1'b1;
            out_last  = (rd_cnt == LAST_IDX);
            // Output is a pure function of registered buffer/reciprocal, so it holds under backpressure.
            out_data  = (|scaled[PROD_WIDTH-1:DATA_WIDTH]) ? '1 : scaled[DATA_WIDTH-1:0];
            if (out_fire && rd_cnt == LAST_IDX)
               state_next = S_LOAD;
         end
         default: state_next = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_LOAD;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         acc       <= '0;
         sum_out   <= '0;
         recip_reg <= '0;
      end else begin
         state <= state_next;
         case (state)
            S_LOAD: begin
               if (accept) begin
                  acc <= acc_sum;
                  if (wr_cnt == LAST_IDX) begin
                     wr_cnt  <= '0;
                     sum_out <= sum_sat;
                  end else begin
                     wr_cnt <= wr_cnt + 1'b1;
                  end
               end
            end
            S_RECIP: begin
               // A zero sum yields a zero reciprocal instead of whatever the divider returns.
               recip_reg <= (sum_out == '0) ? '0 : recip_in;
            end
            S_OUT: begin
               if (out_fire) begin
                  if (rd_cnt == LAST_IDX) begin
                     rd_cnt    <= '0;
                     acc       <= '0;
                     sum_out   <= '0;
                     recip_reg <= '0;
                  end else begin
                     rd_cnt <= rd_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         frame_buf[wr_cnt] <= in_data;
   end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed bench for softmax_normalizer: hand-computed frames, latency, backpressure and reset.
`timescale 1ns/1ps
module tb_softmax_normalizer;

   localparam int unsigned DW = 32;
   localparam int unsigned NC = 10;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, sum_valid, out_valid, out_ready, out_last;
   logic [DW-1:0] in_data, sum_out, recip_in, out_data;
   logic [DW-1:0] words [NC];
   logic [DW-1:0] expv  [NC];
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   softmax_normalizer #(
      .DATA_WIDTH(32), .FRACTION_BITS(30), .NUM_CLASSES(10), .CNT_WIDTH(4)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .sum_out(sum_out), .sum_valid(sum_valid), .recip_in(recip_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input string tag, input bit gaps, input logic [DW-1:0] exp_sum);
      int guard;
      for (int i = 0; i < NC; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         in_valid = 1'b1;
         in_data  = words[i];
         guard    = 0;
         while (!in_ready && guard < 50) begin
            tick();
            guard++;
         end
         check1({tag, " in_ready"}, in_ready, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
      check1({tag, " sum_valid"}, sum_valid, 1'b1);
      check ({tag, " sum_out"}, sum_out, exp_sum);
      check1({tag, " in_ready_recip"}, in_ready, 1'b0);
      check1({tag, " out_valid_early"}, out_valid, 1'b0);
      tick();
      check1({tag, " sum_valid_pulse"}, sum_valid, 1'b0);
      check1({tag, " first_out_valid"}, out_valid, 1'b1);
   endtask

   task automatic recv_frame(input string tag, input int stall);
      int guard;
      for (int k = 0; k < NC; k++) begin
         out_ready = 1'b0;
         guard     = 0;
         while (!out_valid && guard < 50) begin
            tick();
            guard++;
         end
         check1({tag, " out_valid"}, out_valid, 1'b1);
         for (int s = 0; s < stall; s++) begin
            check ({tag, " data_stall"}, out_data, expv[k]);
            check1({tag, " last_stall"}, out_last, k == NC - 1);
            check1({tag, " in_ready_stall"}, in_ready, 1'b0);
            tick();
         end
         out_ready = 1'b1;
         check ({tag, " data"}, out_data, expv[k]);
         check1({tag, " last"}, out_last, k == NC - 1);
         check1({tag, " in_ready_out"}, in_ready, 1'b0);
         tick();
      end
      out_ready = 1'b0;
      check1({tag, " out_valid_done"}, out_valid, 1'b0);
      check1({tag, " in_ready_done"}, in_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; recip_in = '0;
      tick();
      tick();
      check1("rst in_ready", in_ready, 1'b0);
      check1("rst sum_valid", sum_valid, 1'b0);
      check1("rst out_valid", out_valid, 1'b0);
      check1("rst out_last", out_last, 1'b0);
      check ("rst out_data", out_data, 32'h0);
      check ("rst sum_out", sum_out, 32'h0);
      rst = 1'b0;
      #1;
      check1("post_rst in_ready", in_ready, 1'b1);

      // 10 x 2^-4 sums to 0.625; reciprocal 1.6 gives 0.1 each
      for (int i = 0; i < NC; i++) begin words[i] = 32'h0400_0000; expv[i] = 32'h0666_6666; end
      recip_in = 32'h6666_6666;
      send_frame("uniform", 1'b0, 32'h2800_0000);
      recv_frame("uniform", 0);

      for (int i = 0; i < NC; i++) begin words[i] = '0; expv[i] = '0; end
      words[0] = 32'h4000_0000; expv[0] = 32'h4000_0000;
      recip_in = 32'h4000_0000;
      send_frame("onehot", 1'b0, 32'h4000_0000);
      recv_frame("onehot", 0);

      for (int i = 0; i < NC; i++) begin words[i] = '0; expv[i] = '0; end
      recip_in = 32'hFFFF_FFFF;
      send_frame("zero", 1'b0, 32'h0);
      recv_frame("zero", 0);

      // 0xF0000000 * 2.0 exceeds the word range, as does the 10-word sum
      for (int i = 0; i < NC; i++) begin words[i] = 32'hF000_0000; expv[i] = 32'hFFFF_FFFF; end
      recip_in = 32'h8000_0000;
      send_frame("saturate", 1'b0, 32'hFFFF_FFFF);
      recv_frame("saturate", 0);

      // (i+1)*2^-6 scaled by 0.5 -> (i+1)*2^-7; sum 55*2^-6
      for (int i = 0; i < NC; i++) begin
         words[i] = DW'(i + 1) << 24;
         expv[i]  = DW'(i + 1) << 23;
      end
      recip_in = 32'h2000_0000;
      send_frame("backpressure", 1'b1, 32'h3700_0000);
      recv_frame("backpressure", 2);

      for (int i = 0; i < NC; i++) begin words[i] = 32'h0400_0000; expv[i] = 32'h0666_6666; end
      recip_in = 32'h6666_6666;
      send_frame("back2back", 1'b0, 32'h2800_0000);
      recv_frame("back2back", 0);

      send_frame("midrst", 1'b0, 32'h2800_0000);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check1("midrst out_valid", out_valid, 1'b1);
         check ("midrst data", out_data, 32'h0666_6666);
         tick();
      end
      out_ready = 1'b0;
      rst = 1'b1;
      tick();
      check1("midrst rst out_valid", out_valid, 1'b0);
      check ("midrst rst sum_out", sum_out, 32'h0);
      check1("midrst rst in_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      check1("midrst in_ready", in_ready, 1'b1);
      send_frame("after_rst", 1'b0, 32'h2800_0000);
      recv_frame("after_rst", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
